// File: rtl/nco_sweep_ctrl_if.sv
// Bundles the sweep request/config inputs and the NCO drive outputs of nco_sweep_ctrl.
// The master side issues sweep commands; the slave side is the sequencer itself.
interface nco_sweep_ctrl_if #(
  parameter int W  = 32,
  parameter int CW = 16
);
  logic          i_start;
  logic          i_abort;
  logic [W-1:0]  i_f0;
  logic [W-1:0]  i_df;
  logic [CW-1:0] i_nsteps;
  logic [CW-1:0] i_dwell;
  logic          i_repeat;
  logic          i_tick;
  logic          o_ld;
  logic [W-1:0]  o_dphase;
  logic          o_ce;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_step_idx;

  modport master (
    output i_start, i_abort, i_f0, i_df, i_nsteps, i_dwell, i_repeat, i_tick,
    input  o_ld, o_dphase, o_ce, o_busy, o_done, o_step_idx
  );

  modport slave (
    input  i_start, i_abort, i_f0, i_df, i_nsteps, i_dwell, i_repeat, i_tick,
    output o_ld, o_dphase, o_ce, o_busy, o_done, o_step_idx
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep sequencer driving NCO load/step/enable; start -> o_ld one cycle later.
// No backpressure: starts outside IDLE are dropped, abort returns to IDLE at the next edge.
module nco_sweep_ctrl #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input logic             i_clk,
  input logic             i_reset,
  nco_sweep_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state;
  logic          ld;
  logic          ce;
  logic          busy;
  logic          done;
  logic [W-1:0]  dphase;
  logic [CW-1:0] step_idx;
  logic [CW-1:0] dwell_cnt;

  logic [W-1:0]  sh_f0;
  logic [W-1:0]  sh_df;
  logic [CW-1:0] sh_nsteps;
  logic [CW-1:0] sh_dwell;
  logic          sh_repeat;

  logic in_sweep;
  assign in_sweep = (state == ST_LOAD) || (state == ST_DWELL);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      ld        <= 1'b0;
      ce        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dphase    <= '0;
      step_idx  <= '0;
      dwell_cnt <= '0;
      sh_f0     <= '0;
      sh_df     <= '0;
      sh_nsteps <= '0;
      sh_dwell  <= '0;
      sh_repeat <= 1'b0;
    end else if (bus.i_abort) begin
      // NCO keeps its last step: phase word and index are left alone.
      state <= ST_IDLE;
      ld    <= 1'b0;
      ce    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ld   <= 1'b0;
      done <= 1'b0;
      ce   <= bus.i_tick && in_sweep;
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            sh_f0     <= bus.i_f0;
            sh_df     <= bus.i_df;
            sh_nsteps <= bus.i_nsteps;
            sh_dwell  <= bus.i_dwell;
            sh_repeat <= bus.i_repeat;
            if (bus.i_nsteps == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              dphase   <= bus.i_f0;
              step_idx <= '0;
              state    <= ST_LOAD;
              ld       <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          dwell_cnt <= (sh_dwell == '0) ? CW'(1) : sh_dwell;
          state     <= ST_DWELL;
        end
        ST_DWELL: begin
          if (bus.i_tick) begin
            if (dwell_cnt == CW'(1)) begin
              if (step_idx < sh_nsteps - CW'(1)) begin
                step_idx <= step_idx + CW'(1);
                dphase   <= dphase + sh_df;
                state    <= ST_LOAD;
                ld       <= 1'b1;
              end else if (sh_repeat) begin
                step_idx <= '0;
                dphase   <= sh_f0;
                state    <= ST_LOAD;
                ld       <= 1'b1;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              dwell_cnt <= dwell_cnt - CW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ld       = ld;
  assign bus.o_dphase   = dphase;
  assign bus.o_ce       = ce;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_step_idx = step_idx;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed sweep scenarios plus random traffic, scored against
// a step/tick-count model where each step's phase is f0 + k*df.
module tb_nco_sweep_ctrl;
  localparam int W  = 32;
  localparam int CW = 16;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  nco_sweep_ctrl_if #(.W(W), .CW(CW)) bus ();

  nco_sweep_ctrl #(.W(W), .CW(CW)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // model: sweep active, first cycle of a step, done pulse, step k, counted ticks in step
  bit            m_busy, m_ld, m_done, m_ce;
  logic [W-1:0]  m_phase;
  int            m_k, m_cnt;
  logic [W-1:0]  c_f0, c_df;
  int            c_n, c_dw;
  bit            c_rpt;

  logic [W-1:0]  ld_q[$];
  int            ld_t[$];
  int            n_ld, n_done, n_ce, cyc_n;

  task automatic model();
    bit tk;
    int eff;
    tk = bus.i_tick;
    if (i_reset) begin
      m_busy = 0; m_ld = 0; m_done = 0; m_ce = 0;
      m_phase = '0; m_k = 0; m_cnt = 0;
      c_f0 = '0; c_df = '0; c_n = 0; c_dw = 0; c_rpt = 0;
    end else if (bus.i_abort) begin
      m_busy = 0; m_ld = 0; m_done = 0; m_ce = 0;
    end else begin
      m_ce = tk && m_busy;
      if (m_done) begin
        m_done = 0;
      end else if (!m_busy) begin
        if (bus.i_start) begin
          c_f0 = bus.i_f0; c_df = bus.i_df; c_n = int'(bus.i_nsteps);
          c_dw = int'(bus.i_dwell); c_rpt = bus.i_repeat;
          if (c_n == 0) begin
            m_done = 1;
          end else begin
            m_k = 0; m_cnt = 0; m_busy = 1; m_ld = 1; m_phase = c_f0;
          end
        end
      end else if (m_ld) begin
        m_ld = 0;
      end else if (tk) begin
        eff = (c_dw == 0) ? 1 : c_dw;
        m_cnt++;
        if (m_cnt >= eff) begin
          m_cnt = 0;
          if (m_k + 1 < c_n) begin
            m_k++; m_ld = 1;
          end else if (c_rpt) begin
            m_k = 0; m_ld = 1;
          end else begin
            m_busy = 0; m_done = 1;
          end
          m_phase = c_f0 + c_df * W'(m_k);
        end
      end
    end
  endtask

  task automatic cyc(input bit tk);
    bus.i_tick = tk;
    model();
    @(posedge i_clk);
    #1;
    cyc_n++;
    chk("ld",       32'(bus.o_ld),       32'(m_ld));
    chk("ce",       32'(bus.o_ce),       32'(m_ce));
    chk("busy",     32'(bus.o_busy),     32'(m_busy));
    chk("done",     32'(bus.o_done),     32'(m_done));
    chk("dphase",   bus.o_dphase,        m_phase);
    chk("step_idx", 32'(bus.o_step_idx), 32'(m_k));
    if (bus.o_ld) begin
      ld_q.push_back(bus.o_dphase);
      ld_t.push_back(cyc_n);
      n_ld++;
    end
    n_done += int'(bus.o_done);
    n_ce   += int'(bus.o_ce);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    i_reset     = 1'b0;
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++)
      cyc(period == 0 ? bit'($urandom_range(0, 2) != 0) : bit'(i % period == 0));
  endtask

  task automatic clr();
    ld_q.delete(); ld_t.delete();
    n_ld = 0; n_done = 0; n_ce = 0;
  endtask

  task automatic start_sweep(input logic [W-1:0] f0, input logic [W-1:0] df,
                             input int n, input int dw, input bit rpt);
    bus.i_f0 = f0; bus.i_df = df; bus.i_nsteps = CW'(n);
    bus.i_dwell = CW'(dw); bus.i_repeat = rpt; bus.i_start = 1'b1;
  endtask

  task automatic wait_dwell(input string tag);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (m_busy && !m_ld) ok = 1;
      else cyc(1);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bus.i_start = 0; bus.i_abort = 0; bus.i_f0 = '0; bus.i_df = '0;
    bus.i_nsteps = '0; bus.i_dwell = '0; bus.i_repeat = 0; bus.i_tick = 0;
    i_reset = 1;
    cyc(0);
    i_reset = 1;
    cyc(1);
    cyc(0);

    // basic one-shot sweep with sparse ticks
    clr();
    start_sweep(32'h1000, 32'h100, 3, 2, 0);
    run(50, 4);
    chk("t1_nld", 32'(n_ld), 32'd3);
    chk("t1_ph0", ld_q[0], 32'h1000);
    chk("t1_ph1", ld_q[1], 32'h1100);
    chk("t1_ph2", ld_q[2], 32'h1200);
    chk("t1_ndone", 32'(n_done), 32'd1);
    chk("t1_busy", 32'(bus.o_busy), 32'd0);

    // modular wrap and negative increment
    clr();
    start_sweep(32'hFFFFFF80, 32'h100, 2, 1, 0);
    run(20, 1);
    chk("t2_wrap", ld_q[1], 32'h80);
    clr();
    start_sweep(32'h100, 32'hFFFFFFF0, 2, 1, 0);
    run(20, 1);
    chk("t2_neg0", ld_q[0], 32'h100);
    chk("t2_neg1", ld_q[1], 32'hF0);

    // zero steps: immediate done, phase untouched
    clr();
    start_sweep(32'h5, 32'h5, 0, 3, 0);
    cyc(1);
    chk("t3_done", 32'(bus.o_done), 32'd1);
    run(5, 1);
    chk("t3_nld", 32'(n_ld), 32'd0);
    chk("t3_phase", bus.o_dphase, 32'hF0);

    // zero dwell with back-to-back ticks: nsteps*1 + nsteps forwarded ticks
    clr();
    start_sweep(32'h2000, 32'h10, 2, 0, 0);
    run(10, 1);
    chk("t4_nce", 32'(n_ce), 32'd4);
    chk("t4_gap", 32'(ld_t[1] - ld_t[0]), 32'd2);

    // repeat mode, then abort from DWELL
    clr();
    start_sweep(32'h40, 32'h20, 2, 3, 1);
    run(40, 2);
    chk("t5_nld", 32'(n_ld >= 4), 32'd1);
    wait_dwell("t5_reach");
    bus.i_abort = 1'b1;
    cyc(1);
    chk("t5_ce", 32'(bus.o_ce), 32'd0);
    run(5, 1);
    chk("t5_ndone", 32'(n_done), 32'd0);

    // start while busy ignored, reset in DWELL, fresh start afterwards
    clr();
    start_sweep(32'h1000, 32'h10, 4, 5, 0);
    cyc(1);
    start_sweep(32'hDEAD, 32'h1, 1, 1, 0);
    run(15, 1);
    chk("t6_ph1", ld_q[1], 32'h1010);
    wait_dwell("t6_reach");
    i_reset = 1'b1;
    cyc(1);
    chk("t6_rst_ph", bus.o_dphase, 32'h0);
    chk("t6_rst_busy", 32'(bus.o_busy), 32'd0);
    start_sweep(32'h2222, 32'h1, 1, 1, 0);
    cyc(0);
    chk("t6_new_ph", bus.o_dphase, 32'h2222);
    run(10, 1);

    // random traffic
    for (int it = 0; it < 30; it++) begin
      start_sweep($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                  bit'($urandom_range(0, 1)));
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 99) < 2) bus.i_abort = 1'b1;
        if ($urandom_range(0, 99) < 3)
          start_sweep($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                      bit'($urandom_range(0, 1)));
        if ($urandom_range(0, 99) < 1) i_reset = 1'b1;
        cyc(bit'($urandom_range(0, 2) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
